// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execution sequencer and its helpers.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETTLE  = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/signed-overflow flags for an ALU result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] res_i,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
);

    localparam int S = WIDTH - 1;

    always_comb begin
        zero_o = (res_i == '0);
        neg_o  = res_i[S];
        ovf_o  = 1'b0;
        // Overflow only has meaning for the two arithmetic opcodes.
        case (op_i)
            ALU_OP_ADD: ovf_o = (a_i[S] == b_i[S]) && (res_i[S] != a_i[S]);
            ALU_OP_SUB: ovf_o = (a_i[S] != b_i[S]) && (res_i[S] != a_i[S]);
            default:    ovf_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencer in front of the combinational ALU: latches a request, enables the
// ALU bus driver for a settle window, samples the result and returns it with flags.
//
// state   | meaning
// IDLE    | ready for a request, ALU bus driver off
// SETTLE  | operands applied, ALU driving the bus, settle counter running
// CAPTURE | final enabled cycle; result bus sampled at its closing edge
// RESP    | response held until RSP_READY, ALU bus driver off
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [2:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    output logic [WIDTH-1:0] ALU_IN1,
    output logic [WIDTH-1:0] ALU_IN2,
    output logic [2:0]       ALU_OP,
    output logic             ALU_OUT_EN,
    input  logic [WIDTH-1:0] RES_BUS,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic             RSP_ZERO,
    output logic             RSP_NEG,
    output logic             RSP_OVF,
    output logic             BUSY
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_exec_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [WIDTH-1:0]   in1_q;
    logic [WIDTH-1:0]   in2_q;
    logic [2:0]         op_q;
    logic               out_en_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_zero_q;
    logic               rsp_neg_q;
    logic               rsp_ovf_q;
    logic               req_ready_q;
    logic               busy_q;

    logic               flag_zero;
    logic               flag_neg;
    logic               flag_ovf;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .a_i    (in1_q),
        .b_i    (in2_q),
        .op_i   (op_q),
        .res_i  (RES_BUS),
        .zero_o (flag_zero),
        .neg_o  (flag_neg),
        .ovf_o  (flag_ovf)
    );

    // The async clear of out_en_q releases the shared bus the moment reset asserts.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= '0;
            out_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        in1_q       <= REQ_A;
                        in2_q       <= REQ_B;
                        op_q        <= REQ_OP;
                        out_en_q    <= 1'b1;
                        cnt_q       <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    rsp_data_q  <= RES_BUS;
                    rsp_zero_q  <= flag_zero;
                    rsp_neg_q   <= flag_neg;
                    rsp_ovf_q   <= flag_ovf;
                    out_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_READY  = req_ready_q;
    assign ALU_IN1    = in1_q;
    assign ALU_IN2    = in2_q;
    assign ALU_OP     = op_q;
    assign ALU_OUT_EN = out_en_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_ZERO   = rsp_zero_q;
    assign RSP_NEG    = rsp_neg_q;
    assign RSP_OVF    = rsp_ovf_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl with a behavioural ALU on the result bus.
module tb_alu_exec_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic        z;
        logic        n;
        logic        o;
    } exp_t;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // SETTLE_CYCLES = 1 instance
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1;
    logic [2:0]  req_op = 3'd0, alu_op;
    logic [15:0] req_a = '0, req_b = '0, alu_in1, alu_in2, res_bus, rsp_data;
    logic        alu_out_en, rsp_zero, rsp_neg, rsp_ovf, busy;

    // SETTLE_CYCLES = 4 instance
    logic        req_valid4 = 1'b0, req_ready4, rsp_valid4, rsp_ready4 = 1'b1;
    logic [2:0]  req_op4 = 3'd0, alu_op4;
    logic [15:0] req_a4 = '0, req_b4 = '0, alu_in14, alu_in24, res_bus4, rsp_data4;
    logic        alu_out_en4, rsp_zero4, rsp_neg4, rsp_ovf4, busy4;

    exp_t sb_q[$];
    exp_t sb4_q[$];

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return b;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
        exp_t e;
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        e.data = alu_fn(op, a, b);
        e.z = (e.data == 16'h0000);
        e.n = e.data[15];
        e.o = 1'b0;
        if (op == 3'd0) begin
            s = sa + sb;
            e.o = (s > 32767) || (s < -32768);
        end else if (op == 3'd1) begin
            s = sa - sb;
            e.o = (s > 32767) || (s < -32768);
        end
        return e;
    endfunction

    // Behavioural ALU: drives a junk pattern whenever its driver is disabled.
    assign res_bus  = alu_out_en  ? alu_fn(alu_op,  alu_in1,  alu_in2)  : 16'hDEAD;
    assign res_bus4 = alu_out_en4 ? alu_fn(alu_op4, alu_in14, alu_in24) : 16'hDEAD;

    alu_exec_ctrl #(.WIDTH(16), .SETTLE_CYCLES(1)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
        .REQ_A(req_a), .REQ_B(req_b),
        .ALU_IN1(alu_in1), .ALU_IN2(alu_in2), .ALU_OP(alu_op), .ALU_OUT_EN(alu_out_en),
        .RES_BUS(res_bus),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
        .RSP_ZERO(rsp_zero), .RSP_NEG(rsp_neg), .RSP_OVF(rsp_ovf), .BUSY(busy)
    );

    alu_exec_ctrl #(.WIDTH(16), .SETTLE_CYCLES(4)) dut4 (
        .CLK(clk), .RESET_N(rst_n),
        .REQ_VALID(req_valid4), .REQ_READY(req_ready4), .REQ_OP(req_op4),
        .REQ_A(req_a4), .REQ_B(req_b4),
        .ALU_IN1(alu_in14), .ALU_IN2(alu_in24), .ALU_OP(alu_op4), .ALU_OUT_EN(alu_out_en4),
        .RES_BUS(res_bus4),
        .RSP_VALID(rsp_valid4), .RSP_READY(rsp_ready4), .RSP_DATA(rsp_data4),
        .RSP_ZERO(rsp_zero4), .RSP_NEG(rsp_neg4), .RSP_OVF(rsp_ovf4), .BUSY(busy4)
    );

    // Called right after the negedge on which a request was driven; drops
    // REQ_VALID after the accept edge and returns the response plus edges from accept.
    task automatic get_rsp1(output exp_t got, output int edges, output bit ok);
        int k;
        k = 0;
        ok = 1'b0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        edges = k - 1;
        got = '{data: rsp_data, z: rsp_zero, n: rsp_neg, o: rsp_ovf};
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL rsp_timeout: no RSP_VALID within %0d cycles", k);
        end
    endtask

    task automatic drive1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        sb_q.push_back(model(op, a, b));
    endtask

    task automatic test_reset();
        exp_t got, e;
        int edges;
        bit ok;
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 16'h7FFF;
        req_b = 16'h0001;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({alu_out_en, rsp_valid, rsp_zero, rsp_neg, rsp_ovf, busy, req_ready} !== 7'b0000001)
            begin errors++; $display("FAIL reset_ctrl: got %b want 0000001",
                {alu_out_en, rsp_valid, rsp_zero, rsp_neg, rsp_ovf, busy, req_ready}); end
        checks++;
        if ({alu_in1, alu_in2, alu_op, rsp_data} !== 51'd0)
            begin errors++; $display("FAIL reset_data: in1=%h in2=%h op=%h data=%h want 0",
                alu_in1, alu_in2, alu_op, rsp_data); end
        checks++;
        if ({alu_out_en4, rsp_valid4, busy4, req_ready4} !== 4'b0001)
            begin errors++; $display("FAIL reset_ctrl4: got %b want 0001",
                {alu_out_en4, rsp_valid4, busy4, req_ready4}); end
        // Release reset with the ADD request already pending.
        sb_q.push_back(model(3'd0, 16'h7FFF, 16'h0001));
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || alu_in1 !== 16'h7FFF || alu_out_en !== 1'b1)
            begin errors++; $display("FAIL first_accept: busy=%b in1=%h en=%b want 1 7fff 1",
                busy, alu_in1, alu_out_en); end
        req_valid = 1'b0;
        get_rsp1(got, edges, ok);
        edges = edges + 1;
        if (ok) begin
            e = sb_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL add_ovf: got %h/%b%b%b want %h/%b%b%b",
                got.data, got.z, got.n, got.o, e.data, e.z, e.n, e.o); end
            checks++;
            if (got !== exp_t'({16'h8000, 1'b0, 1'b1, 1'b1}))
                begin errors++; $display("FAIL add_ovf_const: got %h want 8000 z0 n1 o1", got.data); end
            checks++;
            if (edges != 2) begin errors++; $display("FAIL add_latency: got %0d want 2", edges); end
        end
    endtask

    task automatic test_arith();
        exp_t got, e;
        int edges;
        bit ok;
        logic [2:0]  ops [4] = '{3'd1, 3'd0, 3'd1, 3'd3};
        logic [15:0] as  [4] = '{16'h0005, 16'h8000, 16'h8000, 16'h00F0};
        logic [15:0] bs  [4] = '{16'h0005, 16'h8000, 16'h0001, 16'h0F0F};
        for (int i = 0; i < 4; i++) begin
            drive1(ops[i], as[i], bs[i]);
            get_rsp1(got, edges, ok);
            if (ok) begin
                e = sb_q.pop_front();
                checks++;
                if (got !== e) begin errors++;
                    $display("FAIL arith[%0d]: got %h/%b%b%b want %h/%b%b%b", i,
                        got.data, got.z, got.n, got.o, e.data, e.z, e.n, e.o); end
                checks++;
                if (edges != 2) begin errors++;
                    $display("FAIL arith_latency[%0d]: got %0d want 2", i, edges); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_settle4();
        exp_t got, e;
        int k, en_cnt;
        bit ok;
        @(negedge clk);
        req_op4 = 3'd1;
        req_a4 = 16'h0005;
        req_b4 = 16'h0005;
        req_valid4 = 1'b1;
        sb4_q.push_back(model(3'd1, 16'h0005, 16'h0005));
        k = 0;
        en_cnt = 0;
        ok = 1'b0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid4 = 1'b0;
            if (alu_out_en4 === 1'b1) en_cnt++;
            if (rsp_valid4 === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL s4_timeout: no RSP_VALID within %0d cycles", k); end
        else begin
            got = '{data: rsp_data4, z: rsp_zero4, n: rsp_neg4, o: rsp_ovf4};
            e = sb4_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL s4_sub: got %h/%b%b%b want %h/%b%b%b",
                got.data, got.z, got.n, got.o, e.data, e.z, e.n, e.o); end
            checks++;
            if (k - 1 != 5) begin errors++; $display("FAIL s4_latency: got %0d want 5", k - 1); end
            checks++;
            if (en_cnt != 5) begin errors++; $display("FAIL s4_out_en_cycles: got %0d want 5", en_cnt); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t got, e;
        int edges;
        bit ok;
        rsp_ready = 1'b0;
        drive1(3'd0, 16'h1234, 16'h1111);
        get_rsp1(got, edges, ok);
        if (ok) begin
            e = sb_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL stall_data: got %h want %h", got.data, e.data); end
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== e.data || alu_out_en !== 1'b0 ||
                    req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: valid=%b data=%h en=%b rdy=%b want 1 %h 0 0",
                        i, rsp_valid, rsp_data, alu_out_en, req_ready, e.data);
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_data !== e.data)
                begin errors++; $display("FAIL stall_release: valid=%b rdy=%b busy=%b data=%h want 0 1 0 %h",
                    rsp_valid, req_ready, busy, rsp_data, e.data); end
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset_midop();
        exp_t got, e;
        int edges, seen;
        bit ok;
        @(negedge clk);
        req_op = 3'd0;
        req_a = 16'h4000;
        req_b = 16'h4000;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (alu_out_en !== 1'b1) begin errors++; $display("FAIL midop_en_before: got %b want 1", alu_out_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (alu_out_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL midop_async: en=%b busy=%b rdy=%b want 0 0 1",
                alu_out_en, busy, req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midop_no_rsp: got %0d response cycles want 0", seen); end
        drive1(3'd0, 16'h0003, 16'h0004);
        get_rsp1(got, edges, ok);
        if (ok) begin
            e = sb_q.pop_front();
            checks++;
            if (got.data !== 16'h0007 || got !== e)
                begin errors++; $display("FAIL midop_after: got %h want 0007", got.data); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        logic [2:0]  ops [4] = '{3'd0, 3'd5, 3'd1, 3'd5};
        logic [15:0] as  [4] = '{16'h0100, 16'h7FFF, 16'h8000, 16'h8000};
        logic [15:0] bs  [4] = '{16'h0023, 16'h0001, 16'h0001, 16'h8000};
        int cyc, prev_acc, rsp_seen, k;
        logic prev_busy;
        bit ok;
        cyc = 0;
        prev_acc = -1;
        rsp_seen = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        prev_busy = busy;
        for (int i = 0; i < 4; i++) begin
            req_op = ops[i];
            req_a = as[i];
            req_b = bs[i];
            req_valid = 1'b1;
            sb_q.push_back(model(ops[i], as[i], bs[i]));
            ok = 1'b0;
            k = 0;
            while (k < 40 && !ok) begin
                @(negedge clk);
                k++;
                cyc++;
                if (rsp_valid === 1'b1 && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    got = '{data: rsp_data, z: rsp_zero, n: rsp_neg, o: rsp_ovf};
                    rsp_seen++;
                    checks++;
                    if (got !== e) begin errors++; $display("FAIL b2b_rsp[%0d]: got %h/%b%b%b want %h/%b%b%b",
                        rsp_seen, got.data, got.z, got.n, got.o, e.data, e.z, e.n, e.o); end
                end
                if (busy === 1'b1 && prev_busy === 1'b0) ok = 1'b1;
                prev_busy = busy;
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_accept_timeout[%0d]", i); end
            else if (prev_acc >= 0 && cyc - prev_acc != 4) begin
                errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, cyc - prev_acc);
            end
            prev_acc = cyc;
        end
        req_valid = 1'b0;
        k = 0;
        while (k < 20 && rsp_seen < 4) begin
            @(negedge clk);
            k++;
            if (rsp_valid === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = '{data: rsp_data, z: rsp_zero, n: rsp_neg, o: rsp_ovf};
                rsp_seen++;
                checks++;
                if (got !== e) begin errors++; $display("FAIL b2b_rsp[%0d]: got %h/%b%b%b want %h/%b%b%b",
                    rsp_seen, got.data, got.z, got.n, got.o, e.data, e.z, e.n, e.o); end
                if (rsp_seen == 4) begin
                    checks++;
                    if (got.o !== 1'b0) begin errors++; $display("FAIL b2b_op5_ovf: got %b want 0", got.o); end
                end
            end
        end
        checks++;
        if (rsp_seen != 4) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 4", rsp_seen); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_settle4();
        test_stall();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Sequencer directly upstream of the 16-bit combinational ALU.
- Accepts an operation request, registers the operands and opcode, and drives them onto the ALU's IN1/IN2/OpControl.
- Enables the ALU's tri-state OUT driver for a fixed settle window, then samples the shared result bus.
- Returns the result with zero/negative/overflow flags over a valid/ready response channel.

Parameters:
- WIDTH, 16, datapath width; must match the ALU.
- SETTLE_CYCLES, 1, cycles the ALU output is enabled before sampling; range 1..15; 0 is an elaboration error.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  high only in IDLE.
- REQ_OP  in  3  ALU opcode.
- REQ_A  in  WIDTH  first operand.
- REQ_B  in  WIDTH  second operand.
- ALU_IN1  out  WIDTH  registered operand A to the ALU.
- ALU_IN2  out  WIDTH  registered operand B to the ALU.
- ALU_OP  out  3  registered opcode to the ALU.
- ALU_OUT_EN  out  1  ALU tri-state output enable; high means the ALU drives the bus.
- RES_BUS  in  WIDTH  shared bus carrying the ALU output.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accepted.
- RSP_DATA  out  WIDTH  captured result.
- RSP_ZERO  out  1  RSP_DATA == 0.
- RSP_NEG  out  1  RSP_DATA[WIDTH-1].
- RSP_OVF  out  1  signed overflow; valid for ADD/SUB only.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset values (applied asynchronously while RESET_N = 0):
  - state = IDLE.
  - ALU_IN1, ALU_IN2, ALU_OP, RSP_DATA = 0.
  - ALU_OUT_EN, RSP_VALID, RSP_ZERO, RSP_NEG, RSP_OVF, BUSY = 0.
  - REQ_READY = 1 after reset.
- ALU_OUT_EN is a registered output and drops in the same instant reset asserts, including mid-operation. No bus contention is allowed after reset.
- Opcodes: ADD = 3'b000, SUB = 3'b001 (IN1 - IN2). All other codes are passed to the ALU unchanged; RSP_OVF = 0 for them.
- State machine IDLE -> SETTLE -> CAPTURE -> RESP -> IDLE:
  - IDLE:
    - REQ_READY = 1.
    - On REQ_VALID: latch REQ_A/REQ_B/REQ_OP into ALU_IN1/ALU_IN2/ALU_OP.
    - Set ALU_OUT_EN = 1 and load cnt = SETTLE_CYCLES-1; go to SETTLE.
    - Without REQ_VALID: stay; operand registers hold their last values.
  - SETTLE:
    - ALU_OUT_EN = 1; cnt decrements each cycle.
    - When cnt == 0, go to CAPTURE.
    - Duration is exactly SETTLE_CYCLES cycles.
  - CAPTURE:
    - ALU_OUT_EN = 1 for this one cycle.
    - At the closing edge: RSP_DATA <= RES_BUS; compute flags from the sampled value; ALU_OUT_EN <= 0; RSP_VALID <= 1; go to RESP.
  - RESP:
    - RSP_VALID and RSP_* outputs held stable.
    - On RSP_READY: RSP_VALID <= 0, go to IDLE. RSP_DATA and the flags hold their values until the next capture.
    - Without RSP_READY: stall indefinitely with ALU_OUT_EN = 0.
- Latency: request accepted at edge E; RSP_VALID is high from edge E+SETTLE_CYCLES+1.
- Throughput: with RSP_READY tied high, one operation every SETTLE_CYCLES+3 cycles. There is no overlap of requests.
- Overflow (s = WIDTH-1; a, b = latched operands; r = captured result):
  - ADD: (a[s] == b[s]) && (r[s] != a[s]).
  - SUB: (a[s] != b[s]) && (r[s] != a[s]).
- REQ_A/REQ_B/REQ_OP changing outside the accept edge have no effect.
- REQ_VALID may be held high through the operation; the next request is accepted only in IDLE.
- RSP_READY already high when RSP_VALID rises: completes in one RESP cycle.
- Reset asserted in any state: immediate return to IDLE with reset values. The in-flight request is dropped and no response is produced.
- Unreachable state encodings recover to IDLE with ALU_OUT_EN = 0.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ALU_OP_ADD and ALU_OP_SUB.
  - State enum for IDLE/SETTLE/CAPTURE/RESP.
  - WIDTH default constant.
- One natural sub-module, alu_flag_gen: combinational ZERO/NEG/OVF from the operands, opcode and result. It is reusable by the later status-register block.
- The FSM and counter stay in the top module.

Test Plan:
- Reset with REQ_VALID = 1 -> all outputs 0 and REQ_READY = 1. First edge after RESET_N rises accepts the request.
- ADD, A = 16'h7FFF, B = 16'h0001, bench ALU model drives RES_BUS = A+B when ALU_OUT_EN -> RSP_DATA = 16'h8000, NEG = 1, OVF = 1, ZERO = 0. RSP_VALID rises exactly 2 edges after accept (SETTLE_CYCLES = 1).
- SUB, A = 16'h0005, B = 16'h0005 -> RSP_DATA = 0, ZERO = 1, OVF = 0. Repeat with SETTLE_CYCLES = 4: latency is 5 edges and ALU_OUT_EN is high for exactly 5 cycles.
- RSP_READY held low 10 cycles -> RSP_VALID/DATA stable, ALU_OUT_EN = 0, REQ_READY = 0. Raising RSP_READY returns to IDLE in 1 cycle.
- RESET_N pulsed low during SETTLE -> ALU_OUT_EN falls with no clock edge and no response appears. A new ADD 16'h0003 + 16'h0004 afterwards yields RSP_DATA = 16'h0007.
- Back-to-back requests with REQ_VALID and RSP_READY tied high -> accepts spaced SETTLE_CYCLES+3 cycles apart. Opcode 3'b101 gives OVF = 0 regardless of data.
